// File: rtl/tcp_pkg.sv
// Shared TCP connection definitions: state encodings used by client_side, server_side
// and server_close_fsm, plus the default retransmit parameters.
package tcp_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ESTABLISHED = 3'd1,
        CLOSE_WAIT  = 3'd2,
        LAST_ACK    = 3'd3,
        CLOSED      = 3'd4
    } tcp_state_t;

    localparam int RETX_TIMEOUT_DEFAULT = 16;
    localparam int MAX_RETX_DEFAULT     = 3;

endpackage

// File: rtl/retx_timer.sv
// FIN retransmit timer: a timeout counter that expires every RETX_TIMEOUT enabled cycles
// and a retry counter that reports when MAX_RETX retransmissions have been spent.
module retx_timer
    import tcp_pkg::*;
#(
    parameter int RETX_TIMEOUT = RETX_TIMEOUT_DEFAULT,
    parameter int MAX_RETX     = MAX_RETX_DEFAULT
) (
    input  logic clock,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire,
    output logic exhausted
);

    localparam int TW = $clog2(RETX_TIMEOUT);
    localparam int RW = $clog2(MAX_RETX + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(RETX_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETX);

    logic [TW-1:0] tcnt_reg;
    logic [RW-1:0] rcnt_reg;

    assign expire    = enable && (tcnt_reg == TIMEOUT_LAST);
    assign exhausted = (rcnt_reg == RETRY_LIMIT);

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            tcnt_reg <= '0;
            rcnt_reg <= '0;
        end else if (clear) begin
            tcnt_reg <= '0;
            rcnt_reg <= '0;
        end else if (enable) begin
            if (expire) begin
                // A give-up clears everything so the counters read zero once the FSM leaves.
                tcnt_reg <= '0;
                rcnt_reg <= exhausted ? '0 : rcnt_reg + 1'b1;
            end else begin
                tcnt_reg <= tcnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/server_close_fsm.sv
// Passive-close (responder) side of TCP teardown: ACKs the peer FIN, sends our FIN on
// application close, waits for the final ACK. Define TCP_CLOSE_RETX_EN for FIN retransmit/abort.
module server_close_fsm
    import tcp_pkg::*;
#(
    parameter int RETX_TIMEOUT = RETX_TIMEOUT_DEFAULT,
    parameter int MAX_RETX     = MAX_RETX_DEFAULT
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       OPEN,
    input  logic       RCV_FIN,
    input  logic       RCV_ACK,
    input  logic       Control,
    output logic       SEND_ACK,
    output logic       SEND_FIN,
    output logic [2:0] STATE,
    output logic       DONE,
    output logic       ABORT
);

    tcp_state_t state_reg;
    logic       send_ack_reg;
    logic       send_fin_reg;
    logic       done_reg;

`ifdef TCP_CLOSE_RETX_EN
    logic abort_reg;
    logic expire;
    logic exhausted;
    logic timer_enable;
    logic timer_clear;

    // Counters run only in LAST_ACK and drop to zero on the same edge the final ACK lands.
    assign timer_enable = (state_reg == LAST_ACK);
    assign timer_clear  = !timer_enable || RCV_ACK;

    retx_timer #(
        .RETX_TIMEOUT (RETX_TIMEOUT),
        .MAX_RETX     (MAX_RETX)
    ) u_retx_timer (
        .clock     (clock),
        .rst       (rst),
        .clear     (timer_clear),
        .enable    (timer_enable),
        .expire    (expire),
        .exhausted (exhausted)
    );

    assign ABORT = abort_reg;
`else
    assign ABORT = 1'b0;
`endif

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            send_ack_reg <= 1'b0;
            send_fin_reg <= 1'b0;
            done_reg     <= 1'b0;
`ifdef TCP_CLOSE_RETX_EN
            abort_reg    <= 1'b0;
`endif
        end else begin
            send_ack_reg <= 1'b0;
            send_fin_reg <= 1'b0;
            done_reg     <= 1'b0;
`ifdef TCP_CLOSE_RETX_EN
            abort_reg    <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (OPEN) state_reg <= ESTABLISHED;
                end
                ESTABLISHED: begin
                    if (RCV_FIN) begin
                        send_ack_reg <= 1'b1;
                        state_reg    <= CLOSE_WAIT;
                    end
                end
                CLOSE_WAIT: begin
                    if (RCV_FIN) send_ack_reg <= 1'b1;
                    if (Control) begin
                        send_fin_reg <= 1'b1;
                        state_reg    <= LAST_ACK;
                    end
                end
                LAST_ACK: begin
                    if (RCV_FIN) send_ack_reg <= 1'b1;
                    // DONE is raised on entry so it is high for the single cycle spent in CLOSED.
                    if (RCV_ACK) begin
                        state_reg <= CLOSED;
                        done_reg  <= 1'b1;
                    end
`ifdef TCP_CLOSE_RETX_EN
                    else if (expire) begin
                        if (exhausted) begin
                            abort_reg <= 1'b1;
                            state_reg <= IDLE;
                        end else begin
                            send_fin_reg <= 1'b1;
                        end
                    end
`endif
                end
                CLOSED: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign SEND_ACK = send_ack_reg;
    assign SEND_FIN = send_fin_reg;
    assign DONE     = done_reg;
    assign STATE    = state_reg;

endmodule
